// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states and master identifier.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    // One bit is enough to name either of the two masters.
    typedef logic master_id_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Per-master request/response bundle between a master and the arbiter.
interface dmem_arbiter_if;

    logic        req;
    logic        we;
    logic        lock;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic        rerr;
    logic [31:0] rdata;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rerr, rdata
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rerr, rdata
    );

endinterface

// File: rtl/dmem_arb_rr.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the
// master that was not granted most recently.
module dmem_arb_rr
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  master_id_t last_grant,
    output logic [1:0] gnt
);

    // One-hot grant from the request pair and the previous winner.
    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == 1'b1) ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter with round robin, bounded bus locking,
// address range checking and registered one-cycle responses.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  m0,
    dmem_arbiter_if.slave  m1,
    output logic [31:0]    mem_address,
    output logic [31:0]    mem_write_data,
    output logic           mem_write_enable,
    input  logic [31:0]    mem_read_data
);

    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_t       state, state_nxt;
    master_id_t       last_grant, last_grant_nxt;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;

    logic [1:0]  req;
    logic [1:0]  rr_gnt;
    logic [1:0]  gnt;
    logic        acc;
    logic        in_range;
    logic        sel_err;
    logic        sel_we;
    logic        sel_lock;
    master_id_t  sel_id;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    assign req = {m1.req, m0.req};

    dmem_arb_rr u_rr (
        .req        (req),
        .last_grant (last_grant),
        .gnt        (rr_gnt)
    );

    // Grant: round robin in ARB, only the owner while locked, none in reset.
    always_comb begin
        gnt = '0;
        case (state)
            ARB:     gnt = rr_gnt;
            LOCK0:   gnt = {1'b0, req[0]};
            LOCK1:   gnt = {req[1], 1'b0};
            default: gnt = '0;
        endcase
        if (rst) begin
            gnt = '0;
        end
    end

    assign m0.gnt = gnt[0];
    assign m1.gnt = gnt[1];

    // Route the granted master's request fields; all zero when nobody is granted.
    always_comb begin
        sel_id    = 1'b0;
        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt[0]) begin
            sel_id    = 1'b0;
            sel_we    = m0.we;
            sel_lock  = m0.lock;
            sel_addr  = m0.addr;
            sel_wdata = m0.wdata;
        end else if (gnt[1]) begin
            sel_id    = 1'b1;
            sel_we    = m1.we;
            sel_lock  = m1.lock;
            sel_addr  = m1.addr;
            sel_wdata = m1.wdata;
        end
    end

    assign acc              = |gnt;
    assign in_range         = sel_addr < 32'(DEPTH);
    assign sel_err          = acc & ~in_range;
    assign mem_address      = sel_addr;
    assign mem_write_data   = sel_wdata;
    assign mem_write_enable = acc & sel_we & in_range;

    // Next state: lock entry/exit, hold counter and round-robin history.
    always_comb begin
        state_nxt      = state;
        lock_cnt_nxt   = lock_cnt;
        last_grant_nxt = last_grant;
        if (acc) begin
            last_grant_nxt = sel_id;
        end
        case (state)
            ARB: begin
                lock_cnt_nxt = '0;
                if (acc && sel_lock && !sel_err) begin
                    state_nxt = sel_id ? LOCK1 : LOCK0;
                end
            end
            LOCK0, LOCK1: begin
                lock_cnt_nxt = lock_cnt + 1'b1;
                // The counter value names the cycle just finishing; LOCK_MAX-1
                // is the last permitted one, so release takes effect at this edge.
                if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
                    state_nxt = ARB;
                end else if (acc && (!sel_lock || sel_err)) begin
                    state_nxt = ARB;
                end
            end
            default: begin
                state_nxt    = ARB;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    // FSM and arbitration history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            last_grant <= 1'b1;
            lock_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            lock_cnt   <= lock_cnt_nxt;
        end
    end

    // One-cycle response for every accepted access.
    always_ff @(posedge clk) begin
        if (rst) begin
            m0.rvalid <= 1'b0;
            m0.rerr   <= 1'b0;
            m0.rdata  <= '0;
            m1.rvalid <= 1'b0;
            m1.rerr   <= 1'b0;
            m1.rdata  <= '0;
        end else begin
            m0.rvalid <= gnt[0];
            m0.rerr   <= gnt[0] & sel_err;
            m0.rdata  <= (gnt[0] && !sel_we && !sel_err) ? mem_read_data : '0;
            m1.rvalid <= gnt[1];
            m1.rerr   <= gnt[1] & sel_err;
            m1.rdata  <= (gnt[1] && !sel_we && !sel_err) ? mem_read_data : '0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then constrained-random traffic,
// checked against a transaction-level model of arbitration, locking and memory.
module tb_dmem_arbiter;

    localparam int unsigned DEPTH    = 1024;
    localparam int unsigned LOCK_MAX = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    always #5 clk = ~clk;

    dmem_arbiter_if m0_if ();
    dmem_arbiter_if m1_if ();

    dmem_arbiter #(.DEPTH(DEPTH), .LOCK_MAX(LOCK_MAX)) dut (
        .clk              (clk),
        .rst              (rst),
        .m0               (m0_if),
        .m1               (m1_if),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    function automatic logic [31:0] pattern(int unsigned i);
        return (32'h9E37_79B9 * i) ^ 32'h5A5A_0000;
    endfunction

    // Environment data memory: combinational read, clocked write.
    logic [31:0] env_mem [DEPTH];
    logic        init_mem;

    assign mem_read_data = (mem_address < DEPTH) ? env_mem[mem_address[9:0]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int unsigned i = 0; i < DEPTH; i++) env_mem[i] <= pattern(i);
        end else if (mem_write_enable && mem_address < DEPTH) begin
            env_mem[mem_address[9:0]] <= mem_write_data;
        end
    end

    // Stimulus registers per master.
    logic        r_req  [2];
    logic        r_we   [2];
    logic        r_lock [2];
    logic [31:0] r_addr [2];
    logic [31:0] r_wdata[2];

    // Reference model state.
    logic [31:0] gold [DEPTH];
    int          lock_owner;
    int          lock_age;
    int          last_id;
    logic        exp_rvalid[2];
    logic        exp_rerr  [2];
    logic [31:0] exp_rdata [2];
    logic [1:0]  prev_gnt;

    int n_assert = 0;
    int n_fail   = 0;
    int stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic set_m(input int n, input logic req, input logic we, input logic lock,
                         input logic [31:0] addr, input logic [31:0] wdata);
        r_req[n]   = req;
        r_we[n]    = we;
        r_lock[n]  = lock;
        r_addr[n]  = addr;
        r_wdata[n] = wdata;
    endtask

    task automatic idle(input int n);
        set_m(n, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // One clock cycle: drive inputs, check combinational outputs mid-cycle,
    // advance the model at the edge, then check the registered responses.
    task automatic tick(input string lbl);
        logic [1:0]  eg;
        int          w;
        logic        err;
        logic [31:0] ea, ed;
        logic        ewe;
        m0_if.req = r_req[0]; m0_if.we = r_we[0]; m0_if.lock = r_lock[0];
        m0_if.addr = r_addr[0]; m0_if.wdata = r_wdata[0];
        m1_if.req = r_req[1]; m1_if.we = r_we[1]; m1_if.lock = r_lock[1];
        m1_if.addr = r_addr[1]; m1_if.wdata = r_wdata[1];
        #3;
        eg = 2'b00;
        if (rst) eg = 2'b00;
        else if (lock_owner >= 0) eg[lock_owner] = r_req[lock_owner];
        else if (r_req[0] && r_req[1]) eg[1 - last_id] = 1'b1;
        else eg = {r_req[1], r_req[0]};
        w   = eg[0] ? 0 : (eg[1] ? 1 : -1);
        ea  = (w >= 0) ? r_addr[w] : 32'd0;
        ed  = (w >= 0) ? r_wdata[w] : 32'd0;
        err = (w >= 0) && (ea >= DEPTH);
        ewe = (w >= 0) && r_we[w] && !err;
        chk({lbl, " m0_gnt"}, m0_if.gnt, eg[0]);
        chk({lbl, " m1_gnt"}, m1_if.gnt, eg[1]);
        chk({lbl, " mem_address"}, mem_address, ea);
        chk({lbl, " mem_write_data"}, mem_write_data, ed);
        chk({lbl, " mem_write_enable"}, mem_write_enable, ewe);
        if (m1_if.req && !m1_if.gnt) stall++;
        prev_gnt = eg;
        @(posedge clk);
        for (int n = 0; n < 2; n++) begin
            exp_rvalid[n] = 1'b0; exp_rerr[n] = 1'b0; exp_rdata[n] = 32'd0;
        end
        if (rst) begin
            lock_owner = -1; lock_age = 0; last_id = 1;
        end else begin
            if (w >= 0) begin
                exp_rvalid[w] = 1'b1;
                exp_rerr[w]   = err;
                exp_rdata[w]  = (!err && !r_we[w]) ? gold[ea[9:0]] : 32'd0;
                if (!err && r_we[w]) gold[ea[9:0]] = ed;
                last_id = w;
            end
            if (lock_owner >= 0) begin
                lock_age++;
                if (w == lock_owner && (!r_lock[w] || err)) lock_owner = -1;
                else if (lock_age >= LOCK_MAX) lock_owner = -1;
            end else if (w >= 0 && r_lock[w] && !err) begin
                lock_owner = w; lock_age = 0;
            end
        end
        #1;
        chk({lbl, " m0_rvalid"}, m0_if.rvalid, exp_rvalid[0]);
        chk({lbl, " m0_rerr"},   m0_if.rerr,   exp_rerr[0]);
        chk({lbl, " m0_rdata"},  m0_if.rdata,  exp_rdata[0]);
        chk({lbl, " m1_rvalid"}, m1_if.rvalid, exp_rvalid[1]);
        chk({lbl, " m1_rerr"},   m1_if.rerr,   exp_rerr[1]);
        chk({lbl, " m1_rdata"},  m1_if.rdata,  exp_rdata[1]);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'd1023;
            1:       return 32'd1024;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom;
            default: return 32'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        for (int unsigned i = 0; i < DEPTH; i++) gold[i] = pattern(i);
        lock_owner = -1; lock_age = 0; last_id = 1;
        prev_gnt = 2'b00; stall = 0;
        idle(0); idle(1);
        rst = 1'b1;
        init_mem = 1'b1;
        @(posedge clk); #1;
        init_mem = 1'b0;

        // Reset holds grants low even with requests present.
        tick("reset_idle");
        set_m(0, 1, 1, 1, 32'd3, 32'h1111_1111);
        set_m(1, 1, 0, 0, 32'd4, 32'd0);
        tick("reset_req");
        rst = 1'b0; idle(0); idle(1);
        tick("post_reset");

        // Simultaneous reads after reset: m0 first, m1 next cycle.
        set_m(0, 1, 0, 0, 32'd40, 32'd0);
        set_m(1, 1, 0, 0, 32'd40, 32'd0);
        tick("sim_read_a");
        idle(0);
        tick("sim_read_b");
        idle(1);
        tick("sim_read_c");

        // Write then read back.
        set_m(1, 1, 1, 0, 32'd100, 32'hDEAD_BEEF);
        tick("wr100");
        set_m(1, 1, 0, 0, 32'd100, 32'd0);
        tick("rd100");
        idle(1);
        tick("rd100_resp");

        // Range boundary, including the top of the 32-bit space.
        set_m(0, 1, 1, 0, 32'd1023, 32'hCAFE_0001);
        tick("wr1023");
        set_m(0, 1, 1, 0, 32'd1024, 32'hCAFE_0002);
        tick("wr1024");
        set_m(0, 1, 0, 0, 32'd1023, 32'd0);
        tick("rd1023");
        set_m(0, 1, 0, 0, 32'hFFFF_FFFF, 32'd0);
        tick("rd_max");
        idle(0);
        tick("range_end");

        // Lock then explicit release while m1 keeps requesting.
        set_m(1, 1, 0, 0, 32'd5, 32'd0);
        tick("pre_lock_m1");
        idle(1);
        set_m(0, 1, 1, 1, 32'd50, 32'h0000_0050);
        tick("lock_on");
        set_m(1, 1, 0, 0, 32'd7, 32'd0);
        set_m(0, 1, 0, 0, 32'd50, 32'd0);
        tick("lock_off");
        idle(0);
        tick("after_unlock");
        idle(1);
        tick("unlock_end");

        // Forced release after LOCK_MAX cycles with the owner idle.
        set_m(0, 1, 0, 1, 32'd60, 32'd0);
        tick("force_entry");
        idle(0);
        set_m(1, 1, 0, 0, 32'd8, 32'd0);
        stall = 0;
        for (int i = 0; i < 10; i++) tick("force_wait");
        chk("forced_release_stall", stall, LOCK_MAX);
        idle(1);
        tick("force_end");

        // Reset during a lock held by m1.
        set_m(1, 1, 0, 1, 32'd200, 32'd0);
        tick("lock1_entry");
        idle(1);
        tick("lock1_hold");
        rst = 1'b1;
        set_m(0, 1, 0, 0, 32'd300, 32'd0);
        set_m(1, 1, 0, 1, 32'd301, 32'd0);
        tick("lock1_reset");
        rst = 1'b0;
        set_m(1, 1, 0, 0, 32'd300, 32'd0);
        tick("post_rst_contend");
        idle(0);
        tick("post_rst_m1");
        idle(1);
        tick("post_rst_end");

        // Random traffic; a pending request stays stable until granted.
        for (int c = 0; c < 800; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!(r_req[n] && !prev_gnt[n])) begin
                    set_m(n, $urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 99) < 30, rand_addr(), $urandom);
                end
            end
            rst = ($urandom_range(0, 99) < 2);
            tick("random");
        end
        rst = 1'b0; idle(0); idle(1);
        tick("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DEPTH, default 1024, SHALL give the number of data-memory words; legal addresses are 0..DEPTH-1.
REQ-002 Parameter LOCK_MAX, default 8, SHALL give the maximum number of consecutive cycles one master may hold a lock.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high. Ports: clk in 1, clock; rst in 1, synchronous active-high reset.
REQ-004 Master ports, for n = 0, 1 (mn_gnt is combinational; mn_rvalid, mn_rerr, mn_rdata are registered):
- mn_req in 1: access request.
- mn_we in 1: 1 = write, 0 = read.
- mn_lock in 1: keep the grant after this access.
- mn_addr in 32: word address.
- mn_wdata in 32: write data.
- mn_gnt out 1: request accepted this cycle.
- mn_rvalid out 1: response valid.
- mn_rerr out 1: address error.
- mn_rdata out 32: read data.
REQ-005 Memory-side ports:
- mem_address out 32: to the data memory address input.
- mem_write_data out 32: to the data memory write-data input.
- mem_write_enable out 1: to the data memory write-enable input.
- mem_read_data in 32: combinational read data from the data memory.

Function
REQ-006 An access SHALL be accepted in a cycle where mn_req and mn_gnt are both 1; at most one gnt SHALL be high per cycle.
REQ-007 A requester SHALL hold req, we, lock, addr and wdata stable until gnt; the arbiter SHALL NOT check this.
REQ-008 mem_address and mem_write_data SHALL combinationally mirror the granted master's addr and wdata; with no grant they SHALL be 0.
REQ-009 mem_write_enable SHALL be 1 only when the granted master has we=1 and addr < DEPTH.
REQ-010 Every accepted access SHALL produce exactly one response: mn_rvalid=1 for exactly one cycle, in the cycle after acceptance.
REQ-011 Response contents:
- In-range read: mn_rdata = mem_read_data sampled at the acceptance edge, mn_rerr=0.
- Write: mn_rdata=0, mn_rerr=0.
- addr >= DEPTH: no memory write, mn_rdata=0, mn_rerr=1.
REQ-012 Address comparison SHALL be an unsigned 32-bit compare; DEPTH-1 is legal and DEPTH is an error.
REQ-013 The FSM SHALL have the states ARB, LOCK0 and LOCK1.
REQ-014 In ARB:
- A single requester SHALL be granted.
- If both request, the master not granted most recently SHALL be granted (round robin via a last_grant register).
- last_grant SHALL update on every accepted access.
REQ-015 ARB -> LOCKn SHALL occur when master n's access is accepted with mn_lock=1 and a lock error is not raised.
REQ-016 In LOCKn, only master n SHALL be granted; the other master SHALL be stalled even if it is requesting.
REQ-017 LOCKn -> ARB SHALL occur on either of:
- an accepted mn access with mn_lock=0;
- the lock-hold counter reaching LOCK_MAX cycles in LOCKn (forced release, taking effect at that edge).
REQ-018 The lock-hold counter SHALL be cleared on entry to LOCKn and SHALL increment on every cycle spent in LOCKn, whether or not mn_req is high.
REQ-019 An accepted access with addr >= DEPTH SHALL NOT enter or extend a lock; if it occurs in LOCKn, the FSM SHALL return to ARB.
REQ-020 A forced release with mn_req=1 in the same cycle SHALL still grant and complete that access; the next cycle is arbitrated in ARB with last_grant=n.

Reset
REQ-021 While rst=1, the arbiter SHALL keep:
- state = ARB, last_grant = 1 (so m0 wins the first contention), lock counter = 0;
- all mn_rvalid, mn_rerr = 0 and mn_rdata = 0;
- all gnt = 0 and mem_write_enable = 0.
REQ-022 Reset asserted mid-lock or mid-response SHALL drop the lock and suppress any pending response; the dropped access receives no rvalid.

Structure
REQ-023 A shared package dmem_arb_pkg SHALL hold the FSM state enum (ARB, LOCK0, LOCK1) and the master-id type.
REQ-024 Round-robin selection SHALL be one sub-module, dmem_arb_rr, with inputs req[1:0] and last_grant and output a one-hot grant.

Verification
REQ-025 Simultaneous reads after reset: m0 and m1 both read addr 40 in one cycle -> m0_gnt=1, m1_gnt=0; next cycle m0_rvalid=1 with the stored word; m1 granted in that cycle.
REQ-026 Write then read: m1 writes 0xDEADBEEF to addr 100, then reads addr 100 -> mem_write_enable=1 for one cycle; the read returns m1_rdata=0xDEADBEEF, m1_rerr=0.
REQ-027 Range boundary: m0 writes addr 1023 -> write performed, rerr=0; m0 writes addr 1024 -> mem_write_enable=0, m0_rerr=1, m0_rdata=0.
REQ-028 Lock release: m0 issues lock=1 to addr 50, then lock=0 to addr 50, while m1 requests continuously -> m1_gnt=0 for both m0 accesses; m1 granted in the cycle after m0's lock=0 access.
REQ-029 Forced release: m0 locks and then idles while m1 requests -> m1_gnt rises exactly LOCK_MAX (8) cycles after lock entry.
REQ-030 Reset during lock: rst=1 for one cycle while in LOCK1 -> next cycle state = ARB, all rvalid=0, and m0 wins a simultaneous request.
